// File: rtl/jtframe_ba0_arb.sv
// Round-robin arbiter sharing SDRAM bank 0 among NREQ requesters.
// One transaction in flight; completion returned as a one-hot ok pulse.
module jtframe_ba0_arb #(
  parameter int NREQ = 4,
  parameter int AW   = 22,
  parameter int DW   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*DW-1:0]   req_din,
  input  logic [NREQ*2-1:0]    req_din_m,
  output logic [NREQ-1:0]      req_ok,
  output logic [31:0]          req_dout,
  output logic [AW-1:0]        ba0_addr,
  output logic                 ba0_rd,
  output logic                 ba0_wr,
  output logic [DW-1:0]        ba0_din,
  output logic [1:0]           ba0_din_m,
  input  logic                 ba0_ack,
  input  logic                 ba0_rdy,
  input  logic [31:0]          sdram_dout,
  output logic                 rfsh_en
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_RDY
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]   last;
  logic [IW-1:0]   cur;
  logic [IW-1:0]   win;
  logic [NREQ-1:0] elig;
  logic            any_elig;
  logic            grant;
  logic            ack_hit;
  logic            done;

  logic [AW-1:0] addr_a [NREQ];
  logic [DW-1:0] din_a  [NREQ];
  logic [1:0]    msk_a  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*AW +: AW];
    assign din_a[i]  = req_din[i*DW +: DW];
    assign msk_a[i]  = req_din_m[i*2 +: 2];
  end

  // The requester in its ok cycle is masked so a held level is not re-granted
  assign elig     = (req_rd | req_wr) & ~req_ok;
  assign any_elig = |elig;

  always_comb begin : pick
    logic [IW-1:0] idx;
    logic          found;
    idx   = last;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!found && elig[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (any_elig) state_nx = WAIT_ACK;
      WAIT_ACK: if (ba0_ack)  state_nx = ba0_rdy ? IDLE : WAIT_RDY;
      WAIT_RDY: if (ba0_rdy)  state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    grant   = (state == IDLE) && any_elig;
    ack_hit = (state == WAIT_ACK) && ba0_ack;
    done    = (ack_hit && ba0_rdy) ||
              ((state == WAIT_RDY) && ba0_rdy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= IW'(NREQ - 1);
      cur       <= '0;
      ba0_addr  <= '0;
      ba0_din   <= '0;
      ba0_din_m <= 2'b11;
      ba0_rd    <= 1'b0;
      ba0_wr    <= 1'b0;
      req_ok    <= '0;
      req_dout  <= '0;
      rfsh_en   <= 1'b1;
    end else begin
      if (grant) begin
        cur       <= win;
        ba0_addr  <= addr_a[win];
        ba0_din   <= din_a[win];
        ba0_din_m <= msk_a[win];
        ba0_wr    <= req_wr[win];
        ba0_rd    <= ~req_wr[win];
      end else if (ack_hit) begin
        ba0_rd <= 1'b0;
        ba0_wr <= 1'b0;
      end
      req_ok <= '0;
      if (done) begin
        req_ok[cur] <= 1'b1;
        req_dout    <= sdram_dout;
        last        <= cur;
      end
      rfsh_en <= (state_nx == IDLE) && !any_elig;
    end
  end

endmodule
